// File: rtl/cic_rate_ctrl.sv
// Rate-change sequencer for the CIC + compensation FIR decimation chain: drain, flush, retune, settle.
// Optional DRAIN watchdog enabled by defining CIC_RATE_CTRL_TIMEOUT_EN.
module cic_rate_ctrl #(
  parameter int unsigned SEL_W         = 3,
  parameter int unsigned MAX_SEL       = 4,
  parameter int unsigned DEFAULT_SEL   = 0,
  parameter int unsigned DRAIN_OUTS    = 4,
  parameter int unsigned FLUSH_CYC     = 8,
  parameter int unsigned SETTLE_OUTS   = 16,
  parameter int unsigned DRAIN_TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  input  logic [SEL_W-1:0] cfg_sel,
  output logic             cfg_ready,
  output logic             cfg_err,
  input  logic             fir_out_valid,
  output logic [SEL_W-1:0] decim_sel,
  output logic             chain_enable,
  output logic             chain_flush,
  output logic             in_gate,
  output logic             out_gate,
  output logic             busy,
  output logic             drain_timeout
);

  localparam int unsigned DRAIN_W  = $clog2(DRAIN_OUTS + 1);
  localparam int unsigned FLUSH_W  = $clog2(FLUSH_CYC + 1);
  localparam int unsigned SETTLE_W = $clog2(SETTLE_OUTS + 1);

  typedef enum logic [1:0] {
    ST_FLUSH  = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2,
    ST_DRAIN  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    pending_q, pending_d;
  logic [SEL_W-1:0]    decim_sel_q, decim_sel_d;
  logic [DRAIN_W-1:0]  drain_cnt_q, drain_cnt_d;
  logic [FLUSH_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
  logic                cfg_ready_q, cfg_ready_d;
  logic                cfg_err_q, cfg_err_d;
  logic                chain_enable_q, chain_enable_d;
  logic                chain_flush_q, chain_flush_d;
  logic                in_gate_q, in_gate_d;
  logic                out_gate_q, out_gate_d;
  logic                busy_q, busy_d;

`ifdef CIC_RATE_CTRL_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(DRAIN_TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             drain_timeout_q, drain_timeout_d;
`endif

  // Next state; counters clear to zero whenever they are not advancing in their own state.
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    decim_sel_d  = decim_sel_q;
    drain_cnt_d  = '0;
    flush_cnt_d  = '0;
    settle_cnt_d = '0;
    cfg_err_d    = 1'b0;
`ifdef CIC_RATE_CTRL_TIMEOUT_EN
    tmo_cnt_d       = '0;
    drain_timeout_d = drain_timeout_q;
`endif

    case (state_q)
      ST_RUN: begin
        if (cfg_valid && cfg_ready_q) begin
          if (cfg_sel > SEL_W'(MAX_SEL)) begin
            cfg_err_d = 1'b1;
          end else begin
`ifdef CIC_RATE_CTRL_TIMEOUT_EN
            drain_timeout_d = 1'b0;
`endif
            if (cfg_sel != decim_sel_q) begin
              pending_d = cfg_sel;
              state_d   = ST_DRAIN;
            end
          end
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == DRAIN_W'(DRAIN_OUTS)) begin
          state_d = ST_FLUSH;
        end else begin
          drain_cnt_d = drain_cnt_q + DRAIN_W'(fir_out_valid);
`ifdef CIC_RATE_CTRL_TIMEOUT_EN
          if (tmo_cnt_q == TMO_W'(DRAIN_TIMEOUT - 1)) begin
            state_d         = ST_FLUSH;
            drain_timeout_d = 1'b1;
          end else begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
          end
`endif
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == FLUSH_W'(FLUSH_CYC - 1)) begin
          state_d = ST_SETTLE;
        end else begin
          flush_cnt_d = flush_cnt_q + FLUSH_W'(1);
        end
      end
      ST_SETTLE: begin
        settle_cnt_d = settle_cnt_q;
        if (fir_out_valid) begin
          if (settle_cnt_q == SETTLE_W'(SETTLE_OUTS - 1)) begin
            state_d      = ST_RUN;
            settle_cnt_d = '0;
          end else begin
            settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
          end
        end
      end
      default: state_d = ST_FLUSH;
    endcase

    // The select code only moves on the edge that enters FLUSH.
    if (state_d == ST_FLUSH && state_q != ST_FLUSH) begin
      decim_sel_d = pending_q;
    end

    // Outputs are decoded from the next state so they register in step with it.
    cfg_ready_d    = (state_d == ST_RUN);
    chain_enable_d = (state_d != ST_FLUSH);
    chain_flush_d  = (state_d == ST_FLUSH);
    in_gate_d      = (state_d == ST_RUN) || (state_d == ST_SETTLE);
    out_gate_d     = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    busy_d         = (state_d != ST_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_FLUSH;
      pending_q      <= SEL_W'(DEFAULT_SEL);
      decim_sel_q    <= SEL_W'(DEFAULT_SEL);
      drain_cnt_q    <= '0;
      flush_cnt_q    <= '0;
      settle_cnt_q   <= '0;
      cfg_ready_q    <= 1'b0;
      cfg_err_q      <= 1'b0;
      chain_enable_q <= 1'b0;
      chain_flush_q  <= 1'b1;
      in_gate_q      <= 1'b0;
      out_gate_q     <= 1'b0;
      busy_q         <= 1'b1;
    end else begin
      state_q        <= state_d;
      pending_q      <= pending_d;
      decim_sel_q    <= decim_sel_d;
      drain_cnt_q    <= drain_cnt_d;
      flush_cnt_q    <= flush_cnt_d;
      settle_cnt_q   <= settle_cnt_d;
      cfg_ready_q    <= cfg_ready_d;
      cfg_err_q      <= cfg_err_d;
      chain_enable_q <= chain_enable_d;
      chain_flush_q  <= chain_flush_d;
      in_gate_q      <= in_gate_d;
      out_gate_q     <= out_gate_d;
      busy_q         <= busy_d;
    end
  end

`ifdef CIC_RATE_CTRL_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q       <= '0;
      drain_timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q       <= tmo_cnt_d;
      drain_timeout_q <= drain_timeout_d;
    end
  end

  assign drain_timeout = drain_timeout_q;
`else
  assign drain_timeout = 1'b0;
`endif

  assign cfg_ready    = cfg_ready_q;
  assign cfg_err      = cfg_err_q;
  assign decim_sel    = decim_sel_q;
  assign chain_enable = chain_enable_q;
  assign chain_flush  = chain_flush_q;
  assign in_gate      = in_gate_q;
  assign out_gate     = out_gate_q;
  assign busy         = busy_q;

endmodule
